// File: rtl/axi_boot_copy_master.sv
// axi_boot_copy_master
//   AXI4 initiator that copies a boot image from the BootROM into main memory.
//   Each chunk is read as one INCR burst into a local buffer and then written
//   back out as one INCR burst. This repeats until num_beats words have been
//   copied. Only one transaction is outstanding at a time, and no burst
//   crosses a 4 KiB boundary.
//
//   Ports:
//     clk, rstn           clock, asynchronous active-low reset
//     start               one-cycle pulse that launches a copy (ignored while busy)
//     src_addr, dst_addr  8-byte aligned byte addresses
//     num_beats           number of 64-bit words to copy
//     busy, done, error   status: busy window, done pulse, sticky error
//     cycle_count         busy-cycle counter (only with AXI_BOOT_COPY_PERF_EN)
//     M_AXI_*             AXI4 master AW/W/B/AR/R channels
//
//   Optional feature macro: AXI_BOOT_COPY_PERF_EN enables cycle_count.
//   When the macro is undefined, cycle_count is tied to zero.

`ifndef C_AXI_L2_ADDR_WIDTH
`define C_AXI_L2_ADDR_WIDTH 32
`endif

module axi_boot_copy_master #(
  parameter int unsigned ADDR_W    = `C_AXI_L2_ADDR_WIDTH,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BURST = 16,
  parameter logic [3:0]  AXI_ID    = 4'h0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [15:0]       num_beats,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       cycle_count,
  output logic [3:0]        M_AXI_AWID,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [7:0]        M_AXI_AWLEN,
  output logic [2:0]        M_AXI_AWSIZE,
  output logic [1:0]        M_AXI_AWBURST,
  output logic              M_AXI_AWLOCK,
  output logic [3:0]        M_AXI_AWCACHE,
  output logic [2:0]        M_AXI_AWPROT,
  output logic [3:0]        M_AXI_AWQOS,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [DATA_W-1:0] M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic              M_AXI_WLAST,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [3:0]        M_AXI_BID,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [3:0]        M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARLOCK,
  output logic [3:0]        M_AXI_ARCACHE,
  output logic [2:0]        M_AXI_ARPROT,
  output logic [3:0]        M_AXI_ARQOS,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [3:0]        M_AXI_RID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  localparam int unsigned IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [15:0]       rem_q;
  logic [7:0]        idx_q;
  logic              busy_q, done_q, error_q;
  logic [DATA_W-1:0] buf_mem [MAX_BURST];

  logic              start_acc, last_beat, err_now;
  logic [9:0]        src_room, dst_room;
  logic [16:0]       wide;
  logic [8:0]        chunk;

  // Response IDs are not checked: only one transaction is ever outstanding.
  logic unused_ids;
  assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

  assign start_acc = (state == S_IDLE) && start && !busy_q;

  // Chunk is derived from registered addresses and the remaining count.
  // Those registers change only on the B handshake, so chunk is stable
  // from AR through W without needing its own register.
  always_comb begin
    src_room = 10'((13'h1000 - {1'b0, src_q[11:0]}) >> 3);
    dst_room = 10'((13'h1000 - {1'b0, dst_q[11:0]}) >> 3);
    wide     = {1'b0, rem_q};
    if (wide > 17'(MAX_BURST)) wide = 17'(MAX_BURST);
    if (wide > 17'(src_room))  wide = 17'(src_room);
    if (wide > 17'(dst_room))  wide = 17'(dst_room);
    chunk = 9'(wide);
  end

  assign last_beat = (idx_q == 8'(chunk - 9'd1));
  assign err_now   = error_q || (M_AXI_BVALID && (M_AXI_BRESP != 2'b00));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start_acc) state_nx = (num_beats == 16'd0) ? S_DONE : S_AR;
      S_AR:   if (M_AXI_ARREADY) state_nx = S_R;
      S_R:    if (M_AXI_RVALID && last_beat) state_nx = S_AW;
      S_AW:   if (M_AXI_AWREADY) state_nx = S_W;
      S_W:    if (M_AXI_WREADY && last_beat) state_nx = S_B;
      S_B:    if (M_AXI_BVALID)
                state_nx = ((rem_q == 16'(chunk)) || err_now) ? S_DONE : S_AR;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so no VALID depends on a READY.
  always_comb begin
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    case (state)
      S_AR: M_AXI_ARVALID = 1'b1;
      S_R:  M_AXI_RREADY  = 1'b1;
      S_AW: M_AXI_AWVALID = 1'b1;
      S_W: begin
        M_AXI_WVALID = 1'b1;
        M_AXI_WLAST  = last_beat;
      end
      S_B:  M_AXI_BREADY  = 1'b1;
      default: ;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= (state == S_DONE);
      if (start_acc)   busy_q <= 1'b1;
      else if (done_q) busy_q <= 1'b0;

      if (start_acc) begin
        src_q   <= src_addr;
        dst_q   <= dst_addr;
        rem_q   <= num_beats;
        error_q <= 1'b0;
      end

      case (state)
        S_AR, S_AW: idx_q <= '0;
        S_R: if (M_AXI_RVALID) begin
          idx_q <= idx_q + 8'd1;
          if ((M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != last_beat)) error_q <= 1'b1;
        end
        S_W: if (M_AXI_WREADY) idx_q <= idx_q + 8'd1;
        S_B: if (M_AXI_BVALID) begin
          src_q <= src_q + ADDR_W'({chunk, 3'b000});
          dst_q <= dst_q + ADDR_W'({chunk, 3'b000});
          rem_q <= rem_q - 16'(chunk);
          if (M_AXI_BRESP != 2'b00) error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_R) && M_AXI_RVALID) buf_mem[idx_q[IDX_W-1:0]] <= M_AXI_RDATA;
  end

`ifdef AXI_BOOT_COPY_PERF_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          cyc_q <= '0;
    else if (start_acc) cyc_q <= '0;
    else if (busy_q)    cyc_q <= cyc_q + 32'd1;
  end
  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

  assign M_AXI_ARID    = AXI_ID;
  assign M_AXI_ARADDR  = src_q;
  assign M_AXI_ARLEN   = 8'(chunk - 9'd1);
  assign M_AXI_ARSIZE  = 3'b011;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARQOS   = '0;

  assign M_AXI_AWID    = AXI_ID;
  assign M_AXI_AWADDR  = dst_q;
  assign M_AXI_AWLEN   = 8'(chunk - 9'd1);
  assign M_AXI_AWSIZE  = 3'b011;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = '0;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWQOS   = '0;

  assign M_AXI_WDATA   = buf_mem[idx_q[IDX_W-1:0]];
  assign M_AXI_WSTRB   = '1;

endmodule

// File: tb/tb_axi_boot_copy_master.sv
// Directed testbench for axi_boot_copy_master with AXI responder models.
module tb_axi_boot_copy_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] num_beats;
  logic        busy, done, error;
  logic [31:0] cycle_count;

  logic [3:0]  m_awid, m_awcache, m_awqos, m_arid, m_arcache, m_arqos;
  logic [31:0] m_awaddr, m_araddr;
  logic [7:0]  m_awlen, m_arlen, m_wstrb;
  logic [2:0]  m_awsize, m_awprot, m_arsize, m_arprot;
  logic [1:0]  m_awburst, m_arburst;
  logic        m_awlock, m_awvalid, m_arlock, m_arvalid;
  logic [63:0] m_wdata;
  logic        m_wlast, m_wvalid, m_bready, m_rready;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
  logic [1:0]  s_bresp, s_rresp;
  logic [63:0] s_rdata;

  always #5 clk = ~clk;

  axi_boot_copy_master #(.ADDR_W(32), .DATA_W(64), .MAX_BURST(16), .AXI_ID(4'h0)) dut (
    .clk(clk), .rstn(rstn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_beats(num_beats), .busy(busy), .done(done), .error(error), .cycle_count(cycle_count),
    .M_AXI_AWID(m_awid), .M_AXI_AWADDR(m_awaddr), .M_AXI_AWLEN(m_awlen), .M_AXI_AWSIZE(m_awsize),
    .M_AXI_AWBURST(m_awburst), .M_AXI_AWLOCK(m_awlock), .M_AXI_AWCACHE(m_awcache),
    .M_AXI_AWPROT(m_awprot), .M_AXI_AWQOS(m_awqos), .M_AXI_AWVALID(m_awvalid),
    .M_AXI_AWREADY(s_awready), .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb),
    .M_AXI_WLAST(m_wlast), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(s_wready),
    .M_AXI_BID(4'h0), .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(m_bready),
    .M_AXI_ARID(m_arid), .M_AXI_ARADDR(m_araddr), .M_AXI_ARLEN(m_arlen), .M_AXI_ARSIZE(m_arsize),
    .M_AXI_ARBURST(m_arburst), .M_AXI_ARLOCK(m_arlock), .M_AXI_ARCACHE(m_arcache),
    .M_AXI_ARPROT(m_arprot), .M_AXI_ARQOS(m_arqos), .M_AXI_ARVALID(m_arvalid),
    .M_AXI_ARREADY(s_arready), .M_AXI_RID(4'h0), .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp),
    .M_AXI_RLAST(s_rlast), .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(m_rready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- responder models ----------------
  bit          stall_en = 1'b0;
  int          bresp_err_burst = 0;
  logic [63:0] mem [logic [31:0]];
  logic [7:0]  ar_lens [$];
  logic [7:0]  aw_lens [$];
  int          ar_count = 0, aw_count = 0, b_count = 0;
  int          wbeat_err = 0, stab_err = 0, done_count = 0;
  int          r_left = 0, w_left = 0;
  logic [31:0] r_addr = '0, w_addr = '0;
  bit          b_pend = 1'b0;

  function automatic logic coin();
    return stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a + 32'h1357_9BDF};
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      s_arready <= 1'b0; s_rvalid <= 1'b0; s_rlast <= 1'b0; s_rdata <= '0; s_rresp <= 2'b00;
      r_left = 0;
    end else begin
      if (m_arvalid && s_arready) begin
        r_addr = m_araddr; r_left = int'(m_arlen) + 1; ar_count++; ar_lens.push_back(m_arlen);
      end
      s_arready <= coin();
      if (s_rvalid && m_rready) begin r_left--; r_addr += 32'd8; end
      if (!(s_rvalid && !m_rready)) begin
        if (r_left > 0 && coin()) begin
          s_rvalid <= 1'b1; s_rdata <= pat(r_addr); s_rlast <= (r_left == 1);
        end else begin
          s_rvalid <= 1'b0; s_rlast <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rstn) begin
      s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0; s_bresp <= 2'b00;
      w_left = 0; b_pend = 1'b0;
    end else begin
      if (m_awvalid && s_awready) begin
        w_addr = m_awaddr; w_left = int'(m_awlen) + 1; aw_count++; aw_lens.push_back(m_awlen);
      end
      s_awready <= coin();
      s_wready  <= coin();
      if (m_wvalid && s_wready) begin
        mem[w_addr >> 3] = m_wdata;
        if (m_wlast !== (w_left == 1)) wbeat_err++;
        if (m_wstrb !== 8'hFF) wbeat_err++;
        w_left--; w_addr += 32'd8;
        if (w_left == 0) b_pend = 1'b1;
      end
      if (s_bvalid && m_bready) begin
        s_bvalid <= 1'b0; b_count++;
      end else if (!s_bvalid && b_pend && coin()) begin
        s_bvalid <= 1'b1;
        s_bresp  <= (b_count + 1 == bresp_err_burst) ? 2'b10 : 2'b00;
        b_pend = 1'b0;
      end
    end
  end

  // VALID/payload stability monitor and done-pulse counter
  logic        p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_wl = 0;
  logic [31:0] p_ara = 0, p_awa = 0;
  logic [7:0]  p_arl = 0, p_awl = 0;
  logic [63:0] p_wd = 0;
  always @(posedge clk) begin
    if (rstn) begin
      if (done) done_count++;
      if (p_arv && !p_arr && (!m_arvalid || m_araddr !== p_ara || m_arlen !== p_arl)) stab_err++;
      if (p_awv && !p_awr && (!m_awvalid || m_awaddr !== p_awa || m_awlen !== p_awl)) stab_err++;
      if (p_wv && !p_wr && (!m_wvalid || m_wdata !== p_wd || m_wlast !== p_wl)) stab_err++;
    end
    p_arv = m_arvalid; p_arr = s_arready; p_ara = m_araddr; p_arl = m_arlen;
    p_awv = m_awvalid; p_awr = s_awready; p_awa = m_awaddr; p_awl = m_awlen;
    p_wv = m_wvalid; p_wr = s_wready; p_wd = m_wdata; p_wl = m_wlast;
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    src_addr = s; dst_addr = d; num_beats = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int busy_cyc);
    bit seen = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      if (busy) busy_cyc++;
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_data(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] key = (d >> 3) + 32'(i);
      if (!mem.exists(key)) bad++;
      else if (mem[key] !== pat(s + 32'(8 * i))) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bc, a0, w0, d0, b0;
    rstn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; num_beats = '0;
    repeat (3) @(negedge clk);
    check("rst_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 5'b0);
    check("rst_status", {busy, done, error}, 3'b0);
    check("rst_cycle_count", 64'(cycle_count), 64'd0);
    check("const_fields", {m_arsize, m_arburst, m_awsize, m_awburst, m_wstrb, m_arcache, m_awqos},
          {3'd3, 2'd1, 3'd3, 2'd1, 8'hFF, 4'h0, 4'h0});
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 40 beats, zero-wait: bursts of 16, 16, 8
    mem.delete(); a0 = ar_count; w0 = aw_count; d0 = done_count;
    start_copy(32'h0, 32'h8000_0000, 16'd40);
    wait_done("t40", 2000, bc);
    check("t40_aw_count", 64'(aw_count - w0), 64'd3);
    check("t40_ar_count", 64'(ar_count - a0), 64'd3);
    check("t40_awlen0", 64'(aw_lens[w0]), 64'd15);
    check("t40_awlen1", 64'(aw_lens[w0 + 1]), 64'd15);
    check("t40_awlen2", 64'(aw_lens[w0 + 2]), 64'd7);
    check_data("t40_data", 32'h0, 32'h8000_0000, 40);
    check("t40_done_once", 64'(done_count - d0), 64'd1);
    check("t40_error", 64'(error), 64'd0);
    check("t40_wbeats", 64'(wbeat_err), 64'd0);

    // zero beats: no bursts, done two cycles after start
    a0 = ar_count; w0 = aw_count;
    start_copy(32'h40, 32'h8000_1000, 16'd0);
    wait_done("t0", 20, bc);
    check("t0_busy_cycles", 64'(bc), 64'd2);
    check("t0_busy_after", 64'(busy), 64'd0);
    check("t0_no_bursts", 64'((ar_count - a0) + (aw_count - w0)), 64'd0);

    // destination 32 bytes short of 4 KiB boundary
    mem.delete(); a0 = ar_count; w0 = aw_count;
    start_copy(32'h100, 32'h8000_0FE0, 16'd16);
    wait_done("t4k", 2000, bc);
    check("t4k_aw_count", 64'(aw_count - w0), 64'd2);
    check("t4k_awlen0", 64'(aw_lens[w0]), 64'd3);
    check("t4k_awlen1", 64'(aw_lens[w0 + 1]), 64'd11);
    check("t4k_arlen0", 64'(ar_lens[a0]), 64'd3);
    check("t4k_arlen1", 64'(ar_lens[a0 + 1]), 64'd11);
    check_data("t4k_data", 32'h100, 32'h8000_0FE0, 16);

    // random stalls, 100 beats, plus a start pulse while busy that must be ignored
    mem.delete(); w0 = aw_count; d0 = done_count; stall_en = 1'b1;
    start_copy(32'h2000, 32'h8000_2000, 16'd100);
    repeat (3) @(negedge clk);
    src_addr = 32'h3000; dst_addr = 32'h8000_9000; num_beats = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("tst", 20000, bc);
    stall_en = 1'b0;
    check("tst_aw_count", 64'(aw_count - w0), 64'd7);
    check_data("tst_data", 32'h2000, 32'h8000_2000, 100);
    check("tst_stable", 64'(stab_err), 64'd0);
    check("tst_done_once", 64'(done_count - d0), 64'd1);
    check("tst_wbeats", 64'(wbeat_err), 64'd0);

    // BRESP error on second burst of a 48-beat copy
    a0 = ar_count; d0 = done_count; b0 = b_count;
    bresp_err_burst = b0 + 2;
    start_copy(32'h0, 32'h8000_4000, 16'd48);
    wait_done("terr", 2000, bc);
    bresp_err_burst = 0;
    repeat (4) @(negedge clk);
    check("terr_error", 64'(error), 64'd1);
    check("terr_ar_count", 64'(ar_count - a0), 64'd2);
    check("terr_done_once", 64'(done_count - d0), 64'd1);

    // 16 beats zero-wait: latency and error clear on new start
    start_copy(32'h500, 32'h8000_6000, 16'd16);
    check("tperf_err_cleared", 64'(error), 64'd0);
    wait_done("tperf", 500, bc);
    check("tperf_busy_cycles", 64'(bc), 64'd37);
`ifdef AXI_BOOT_COPY_PERF_EN
    check("tperf_cycle_count", 64'(cycle_count), 64'd37);
`else
    check("tperf_cycle_count", 64'(cycle_count), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_boot_copy_master.md
Name: axi_boot_copy_master

Overview:
- AXI4 initiator that copies a boot image from the 16 KiB BootROM responder into main memory (L2/DDR) before the core is released from reset.
- Issues INCR read bursts to the source, buffers one burst locally, then writes it as an INCR write burst to the destination. Repeats until the programmed beat count is done.
- Sits on the L2 AXI interconnect as a master, beside the core's ports.
- 64-bit data path; one outstanding transaction at a time.

Parameters:
- ADDR_W, `C_AXI_L2_ADDR_WIDTH: AXI address width.
- DATA_W, 64: AXI data width. Only 64 is supported.
- MAX_BURST, 16: maximum beats per burst; also the buffer depth. Power of 2, range 1..256.
- AXI_ID, 4'h0: constant value driven on AWID and ARID.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse; starts a copy; ignored while busy=1
- src_addr  in  ADDR_W  source byte address; 8-byte aligned
- dst_addr  in  ADDR_W  destination byte address; 8-byte aligned
- num_beats  in  16  number of 64-bit words to copy
- busy  out  1  high from the cycle after start until the done cycle, inclusive
- done  out  1  one-cycle pulse when the copy finishes
- error  out  1  sticky error flag; cleared by the next accepted start
- cycle_count  out  32  busy-cycle counter (see Optional Feature)
- M_AXI_AW{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS,VALID}  out  4/ADDR_W/8/3/2/1/4/3/4/1; AWREADY in 1
- M_AXI_W{DATA,STRB,LAST,VALID}  out  64/8/1/1; WREADY in 1
- M_AXI_B{ID,RESP,VALID}  in  4/2/1; BREADY out 1
- M_AXI_AR{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS,VALID}  out  4/ADDR_W/8/3/2/1/4/3/4/1; ARREADY in 1
- M_AXI_R{ID,DATA,RESP,LAST,VALID}  in  4/64/2/1/1; RREADY out 1

Behaviour:
- Reset: all VALID and READY outputs = 0; busy = done = error = 0; cycle_count = 0; FSM in IDLE.
- Constant outputs: SIZE = 3'b011, BURST = 2'b01 (INCR), LOCK/CACHE/PROT/QOS = 0, WSTRB = 8'hFF.
- FSM states and transitions:
  - IDLE: on start, latch src, dst and num_beats. Go to AR, or to DONE if num_beats = 0. Clear error.
  - AR: ARVALID = 1 with a stable ARADDR and ARLEN = chunk-1. Go to R on ARREADY.
  - R: RREADY = 1; store RDATA into buf[idx]. On the last beat go to AW.
  - AW: AWVALID = 1 with AWLEN = chunk-1. Go to W on AWREADY.
  - W: WVALID = 1 with WDATA = buf[idx]; WLAST on beat chunk-1. Go to B on the final handshake.
  - B: BREADY = 1. On BVALID, advance src/dst by chunk*8 and decrement remaining. Go to DONE if remaining = 0 or error = 1; otherwise go to AR.
  - DONE: done = 1 for one cycle, then IDLE.
- Chunk size: chunk = min(remaining, MAX_BURST, beats to the next 4 KiB boundary), where beats to boundary = (4096 - addr[11:0]) >> 3. Compute it separately for src and dst and use the smaller value. No burst ever crosses 4 KiB.
- VALID signals are held until the matching READY. No VALID depends combinationally on a READY. AW is never issued before the read burst fully completes.
- Error conditions set error=1:
  - RRESP != 0 on any beat;
  - RLAST at the wrong beat, or missing on beat chunk-1;
  - BRESP != 0.
- On an R error the FSM still drains the remaining R beats. The write of that chunk still proceeds. The FSM then exits to DONE after B.
- start while busy: ignored, with no effect on the latched values.
- Mid-operation reset: asynchronous return to the reset state. Any outstanding AXI transaction is abandoned; the interconnect is reset together with this block.
- Latency per chunk of N beats with zero-wait responders: 1 (AR) + N + 1 (AW) + N + 1 (B) cycles of FSM time.

Optional Feature:
- Macro: AXI_BOOT_COPY_PERF_EN.
- Defined: cycle_count clears on an accepted start and increments every cycle while busy=1. It holds its value after done.
- Undefined: cycle_count is tied to 0 and the counter logic is absent.

Test Plan:
- src=0x0, dst=0x8000_0000, num_beats=40, zero-wait slaves -> bursts of 16, 16, 8 beats. Destination equals source, done pulses once, error=0.
- num_beats=0 -> no AR or AW issued; done asserts 2 cycles after start; busy high for that interval.
- dst=0x8000_0FE0, num_beats=16 -> first write burst has AWLEN=3 (4 beats to the boundary), second has AWLEN=11. Reads are split to match. Data is correct.
- Random READY/VALID stalls (50%) on all channels, num_beats=100 -> data exact, every VALID stays stable until its handshake, done=1 once.
- BRESP=2'b10 on the second burst of a 48-beat copy -> error=1. No third AR is issued; done pulses.
- With AXI_BOOT_COPY_PERF_EN defined and zero-wait slaves, num_beats=16 -> cycle_count=37.
